alu_seq_unit: RTL and testbench
===============================

ALU_SEQ_UNIT -- requirements
Module: alu_seq_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits (WIDTH >= 4, even).
REQ-002 SHALL have port clock, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin an operation; sampled only while busy=0.
REQ-005 SHALL have port control, input, 4 bits: operation select, captured with start.
REQ-006 SHALL have ports dataA and dataB, input, WIDTH bits each: operands, captured with start.
REQ-007 SHALL have port dataC, output, WIDTH bits: primary result (low product, quotient, or logic/arith result).
REQ-008 SHALL have port dataHi, output, WIDTH bits: high product or remainder; 0 for single-cycle ops.
REQ-009 SHALL have ports busy and done, output, 1 bit each: busy = iterative op in progress; done = one-cycle completion pulse.
REQ-010 SHALL have ports overflow and divZero, output, 1 bit each: signed overflow flag and divide-by-zero flag.

Function
REQ-011 SHALL decode control as follows: 0000 ADD, 0001 SUB, 0010 OR, 0110 AND, 0111 SLT (signed), 0011 SLTU (unsigned), 1000 MULTU, 1001 DIVU. Any other code is a NOP completing with dataC=0.
REQ-012 SHALL use two's complement for ADD/SUB; the result is truncated to WIDTH bits.
- ADD overflow = operands of the same sign and result sign different.
- SUB overflow = operands of differing sign and result sign different from dataA.
REQ-013 SHALL give SLT/SLTU dataC=1 when dataA<dataB (signed/unsigned respectively), else 0.
REQ-014 SHALL, for a single-cycle op or NOP, register dataC/dataHi/flags on the start edge and assert done=1 for exactly the following cycle; busy stays 0.
REQ-015 SHALL implement MULTU as an unsigned shift-add over exactly WIDTH iteration edges after the start edge, with {dataHi,dataC} = the full 2*WIDTH-bit product.
REQ-016 SHALL implement DIVU as unsigned restoring division over exactly WIDTH iteration edges: dataC = quotient, dataHi = remainder.
REQ-017 SHALL use FSM states IDLE -> RUN -> IDLE.
- IDLE: start with MULTU, or with DIVU and dataB!=0, enters RUN, clears the iteration counter and sets busy=1.
- RUN: increments the counter each edge; the WIDTH-th iteration edge writes results, clears busy and pulses done.
REQ-018 SHALL complete DIVU with dataB=0 as a single-cycle op: dataC = all ones, dataHi = dataA, divZero=1.
REQ-019 SHALL ignore start while busy=1; captured operands and control are unaffected.
REQ-020 SHALL hold result outputs stable between completions, and update dataC/dataHi only on a completion edge.
REQ-021 SHALL rewrite overflow and divZero on every completion: 0 unless set by the rules above.
REQ-022 SHALL hold dataC, dataHi and flags at their previous values during RUN.
REQ-023 SHALL accept start in the same cycle that done=1 (back-to-back) when busy=0.

Reset
REQ-024 SHALL, on reset assertion, immediately (without a clock) force state=IDLE, counter=0, and dataC, dataHi, busy, done, overflow and divZero to 0.
REQ-025 SHALL abort any in-progress MULTU/DIVU on reset with no completion pulse; the first start after reset release begins a fresh operation.

Verification (WIDTH=32)
REQ-026 SHALL cover overflow: ADD 0x7FFFFFFF+0x00000001 -> dataC=0x80000000, overflow=1, done one cycle after start, busy never 1. Then SUB 0x80000000-0x00000001 -> 0x7FFFFFFF, overflow=1.
REQ-027 SHALL cover compares: SLT dataA=0xFFFFFFFF, dataB=0x00000001 -> dataC=1. SLTU with the same operands -> dataC=0, overflow=0.
REQ-028 SHALL cover the multiply bound: MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy=1 for 32 cycles, then done with dataHi=0xFFFFFFFE, dataC=0x00000001. A start pulse with control ADD at iteration 5 is ignored.
REQ-029 SHALL cover division: DIVU 100/7 -> done after 32 iteration edges, dataC=14, dataHi=2. DIVU 0x1234/0 -> done next cycle, dataC=0xFFFFFFFF, dataHi=0x1234, divZero=1.
REQ-030 SHALL cover reset mid-operation: reset asserted mid-cycle during MULTU iteration 10 -> all outputs 0 before the next edge, no done pulse. A subsequent ADD 3+4 -> dataC=7.
REQ-031 SHALL cover back-to-back ops: AND 0xF0F0F0F0&0xFF00FF00 -> 0xF000F000, then start OR in the done cycle -> 0xFFF0FFF0 done the next cycle, dataHi=0.

Source files
------------

// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - single-cycle ALU with iterative unsigned multiply/divide
//
// Purpose:
//   Single-cycle ADD/SUB/OR/AND/SLT/SLTU/NOP. MULTU uses shift-add and DIVU
//   uses restoring division; each takes WIDTH iteration edges. All results
//   and flags are registered.
//
// Ports:
//   clock            rising-edge clock
//   reset            asynchronous active-high reset
//   start            begin an operation (sampled only while busy=0)
//   control[3:0]     operation select, captured with start
//   dataA, dataB     operands, captured with start
//   dataC            low product / quotient / logic-arith result
//   dataHi           high product / remainder, 0 for single-cycle ops
//   busy             iterative operation in progress
//   done             one-cycle completion pulse
//   overflow         signed overflow (ADD/SUB)
//   divZero          DIVU with dataB=0
module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] dataC,
    output logic [WIDTH-1:0] dataHi,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             divZero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_OR    = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               is_div_q;
    logic [WIDTH-1:0]   b_q;
    // Working pair: multiply keeps {partial high, multiplier/low product};
    // divide keeps {partial remainder, dividend/quotient}.
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   hi_d, lo_d;

    logic [WIDTH-1:0]   dataC_q, dataHi_q;
    logic               busy_q, done_q, overflow_q, divZero_q;

    // Single-cycle results for the operation presented on the inputs
    logic [WIDTH-1:0]   res_c, res_hi;
    logic               res_ov, res_dz, iter_go;
    logic [WIDTH-1:0]   sum_w, diff_w;

    always_comb begin
        sum_w   = dataA + dataB;
        diff_w  = dataA - dataB;
        res_c   = '0;
        res_hi  = '0;
        res_ov  = 1'b0;
        res_dz  = 1'b0;
        iter_go = 1'b0;
        case (control)
            OP_ADD: begin
                res_c  = sum_w;
                res_ov = (dataA[WIDTH-1] == dataB[WIDTH-1]) &&
                         (sum_w[WIDTH-1] != dataA[WIDTH-1]);
            end
            OP_SUB: begin
                res_c  = diff_w;
                res_ov = (dataA[WIDTH-1] != dataB[WIDTH-1]) &&
                         (diff_w[WIDTH-1] != dataA[WIDTH-1]);
            end
            OP_OR:   res_c = dataA | dataB;
            OP_AND:  res_c = dataA & dataB;
            OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
            OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (dataA < dataB)};
            OP_MULTU: iter_go = 1'b1;
            OP_DIVU: begin
                // Divide by zero never enters RUN; it resolves immediately
                if (dataB == '0) begin
                    res_c  = '1;
                    res_hi = dataA;
                    res_dz = 1'b1;
                end else begin
                    iter_go = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // One iteration step of the active multi-cycle operation
    logic [WIDTH:0] add_w, shift_w, trial_w;

    always_comb begin
        add_w   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        shift_w = {hi_q, lo_q[WIDTH-1]};
        // MSB of trial_w is the borrow: set when the shifted remainder < divisor
        trial_w = shift_w - {1'b0, b_q};
        if (is_div_q) begin
            hi_d = trial_w[WIDTH] ? shift_w[WIDTH-1:0] : trial_w[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ~trial_w[WIDTH]};
        end else begin
            hi_d = add_w[WIDTH:1];
            lo_d = {add_w[0], lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_div_q   <= 1'b0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            dataC_q    <= '0;
            dataHi_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            divZero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (iter_go) begin
                            state_q  <= RUN;
                            busy_q   <= 1'b1;
                            cnt_q    <= '0;
                            is_div_q <= (control == OP_DIVU);
                            b_q      <= dataB;
                            hi_q     <= '0;
                            lo_q     <= dataA;
                        end else begin
                            dataC_q    <= res_c;
                            dataHi_q   <= res_hi;
                            overflow_q <= res_ov;
                            divZero_q  <= res_dz;
                            done_q     <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    hi_q  <= hi_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        dataC_q    <= lo_d;
                        dataHi_q   <= hi_d;
                        overflow_q <= 1'b0;
                        divZero_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dataC    = dataC_q;
    assign dataHi   = dataHi_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = overflow_q;
    assign divZero  = divZero_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb/tb_alu_seq_unit.sv - self-checking bench for alu_seq_unit
module tb_alu_seq_unit;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    control = '0;
    logic [W-1:0]  dataA = '0;
    logic [W-1:0]  dataB = '0;
    logic [W-1:0]  dataC, dataHi;
    logic          busy, done, overflow, divZero;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] prev_c = '0;
    logic [W-1:0] prev_hi = '0;

    alu_seq_unit #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .control(control),
        .dataA(dataA), .dataB(dataB), .dataC(dataC), .dataHi(dataHi),
        .busy(busy), .done(done), .overflow(overflow), .divZero(divZero)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation definitions
    task automatic model_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] ec, output logic [W-1:0] eh,
                            output bit eo, output bit ez, output bit eit);
        longint sa, sb, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ec = '0; eh = '0; eo = 0; ez = 0; eit = 0;
        case (c)
            4'd0: begin r = sa + sb; ec = r[31:0]; eo = (r > SMAX) || (r < SMIN); end
            4'd1: begin r = sa - sb; ec = r[31:0]; eo = (r > SMAX) || (r < SMIN); end
            4'd2: ec = a | b;
            4'd6: ec = a & b;
            4'd7: ec = (sa < sb) ? 32'd1 : 32'd0;
            4'd3: ec = (a < b) ? 32'd1 : 32'd0;
            4'd8: begin p = {32'b0, a} * {32'b0, b}; ec = p[31:0]; eh = p[63:32]; eit = 1; end
            4'd9: begin
                if (b == 0) begin ec = '1; eh = a; ez = 1; end
                else begin ec = a / b; eh = a % b; eit = 1; end
            end
            default: ;
        endcase
    endtask

    // Caller must be away from a rising edge. Returns at the negedge of the done cycle.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int inject);
        logic [W-1:0] ec, eh;
        bit eo, ez, eit, got;
        int busy_cnt;
        model_op(c, a, b, ec, eh, eo, ez, eit);
        control = c; dataA = a; dataB = b; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; control = 4'($urandom); dataA = $urandom; dataB = $urandom;
        busy_cnt = 0; got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clock);
            if (done) got = 1;
            else begin
                if (busy) begin
                    busy_cnt++;
                    check_eq({tag, ".hold"}, {dataHi, dataC}, {prev_hi, prev_c});
                end
                if (busy_cnt == inject) begin
                    start = 1'b1; control = 4'd0; dataA = $urandom; dataB = $urandom;
                end else start = 1'b0;
            end
        end
        start = 1'b0;
        check_eq({tag, ".done"}, 64'(got), 64'd1);
        check_eq({tag, ".busycyc"}, 64'(busy_cnt), eit ? 64'd32 : 64'd0);
        check_eq({tag, ".busy"}, 64'(busy), 64'd0);
        check_eq({tag, ".c"}, 64'(dataC), 64'(ec));
        check_eq({tag, ".hi"}, 64'(dataHi), 64'(eh));
        check_eq({tag, ".ovf"}, 64'(overflow), 64'(eo));
        check_eq({tag, ".dz"}, 64'(divZero), 64'(ez));
        prev_c = ec; prev_hi = eh;
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return W'($urandom_range(0, 20));
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit saw_done;
        int bcnt;
        repeat (3) @(negedge clock);
        check_eq("rst.c", 64'(dataC), 64'd0);
        check_eq("rst.hi", 64'(dataHi), 64'd0);
        check_eq("rst.busy", 64'(busy), 64'd0);
        check_eq("rst.done", 64'(done), 64'd0);
        check_eq("rst.flags", {62'd0, overflow, divZero}, 64'd0);
        reset = 1'b0;
        @(negedge clock);

        run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, -1);
        check_eq("add_ovf.kc", 64'(dataC), 64'h8000_0000);
        check_eq("add_ovf.kv", 64'(overflow), 64'd1);
        run_op("sub_ovf", 4'd1, 32'h8000_0000, 32'h0000_0001, -1);
        check_eq("sub_ovf.kc", 64'(dataC), 64'h7FFF_FFFF);
        check_eq("sub_ovf.kv", 64'(overflow), 64'd1);
        run_op("slt", 4'd7, 32'hFFFF_FFFF, 32'h0000_0001, -1);
        check_eq("slt.kc", 64'(dataC), 64'd1);
        run_op("sltu", 4'd3, 32'hFFFF_FFFF, 32'h0000_0001, -1);
        check_eq("sltu.kc", 64'(dataC), 64'd0);
        check_eq("sltu.kv", 64'(overflow), 64'd0);
        run_op("mul_max", 4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5);
        check_eq("mul_max.khi", 64'(dataHi), 64'hFFFF_FFFE);
        check_eq("mul_max.kc", 64'(dataC), 64'd1);
        @(negedge clock);
        check_eq("mul_max.pulse", 64'(done), 64'd0);
        run_op("div", 4'd9, 32'd100, 32'd7, -1);
        check_eq("div.kc", 64'(dataC), 64'd14);
        check_eq("div.khi", 64'(dataHi), 64'd2);
        run_op("div0", 4'd9, 32'h1234, 32'd0, -1);
        check_eq("div0.kc", 64'(dataC), 64'hFFFF_FFFF);
        check_eq("div0.khi", 64'(dataHi), 64'h1234);
        check_eq("div0.kdz", 64'(divZero), 64'd1);
        run_op("and", 4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, -1);
        check_eq("and.kc", 64'(dataC), 64'hF000_F000);
        run_op("or_b2b", 4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, -1);
        check_eq("or_b2b.kc", 64'(dataC), 64'hFFF0_FFF0);
        check_eq("or_b2b.khi", 64'(dataHi), 64'd0);

        for (int k = 0; k < 60; k++) begin
            logic [3:0] c;
            c = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(8, 9)) : 4'($urandom);
            run_op("rand", c, pick_operand(), pick_operand(),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : -1);
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clock);
                check_eq("rand.pulse", 64'(done), 64'd0);
            end
        end

        // Reset in the middle of a multiply
        control = 4'd8; dataA = '1; dataB = '1; start = 1'b1;
        @(posedge clock); #1; start = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 40 && bcnt < 10; i++) begin
            @(negedge clock);
            if (busy) bcnt++;
        end
        check_eq("rstmid.reach", 64'(bcnt), 64'd10);
        #2 reset = 1'b1;
        #1;
        check_eq("rstmid.c", 64'(dataC), 64'd0);
        check_eq("rstmid.hi", 64'(dataHi), 64'd0);
        check_eq("rstmid.busy", 64'(busy), 64'd0);
        check_eq("rstmid.done", 64'(done), 64'd0);
        check_eq("rstmid.flags", {62'd0, overflow, divZero}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done || busy) saw_done = 1;
        end
        check_eq("rstmid.nodone", 64'(saw_done), 64'd0);
        prev_c = '0; prev_hi = '0;
        run_op("post_rst_add", 4'd0, 32'd3, 32'd4, -1);
        check_eq("post_rst_add.kc", 64'(dataC), 64'd7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
